// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight at a time and
// hands instructions to decode through an output register backed by a 1-entry skid buffer.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_jump_flag,
    input  logic [31:0] i_jump_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_addr,
    input  logic        i_ready
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SKID,
        DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] skid_inst;
    logic [31:0] skid_addr;
    logic        xfer;
    logic        granted;
    logic        load_rdata;
    logic        load_skid;
    logic        fill_skid;

    assign xfer    = o_valid & i_ready;
    assign granted = (state == REQ) & i_imem_gnt;

    // A response may go straight to the output when the slot is free or emptying this cycle.
    assign load_rdata = (state == WAIT) & i_imem_rvalid & (~o_valid | i_ready);
    assign fill_skid  = (state == WAIT) & i_imem_rvalid & o_valid & ~i_ready;
    assign load_skid  = (state == SKID) & xfer;

    assign o_imem_addr = {pc[31:2], 2'b00};

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ:  if (i_imem_gnt) state_next = WAIT;
            WAIT: begin
                if (i_imem_rvalid) state_next = (~o_valid | i_ready) ? REQ : SKID;
            end
            SKID: if (xfer) state_next = REQ;
            DROP: if (i_imem_rvalid) state_next = REQ;
            default: state_next = IDLE;
        endcase

        // A redirect overrides everything; a request already granted must be drained first.
        if (i_jump_flag) begin
            unique case (state)
                REQ:     state_next = i_imem_gnt ? DROP : REQ;
                WAIT:    state_next = i_imem_rvalid ? REQ : DROP;
                DROP:    state_next = i_imem_rvalid ? REQ : DROP;
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            o_imem_req  <= 1'b0;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            skid_inst   <= NOP_INST;
            skid_addr   <= RESET_PC;
            o_valid     <= 1'b0;
            o_inst      <= NOP_INST;
            o_inst_addr <= RESET_PC;
        end else begin
            state      <= state_next;
            o_imem_req <= (state_next == REQ);

            if (i_jump_flag) begin
                pc <= {i_jump_addr[31:2], 2'b00};
            end else if (granted) begin
                pc <= pc + 32'd4;
            end

            if (granted) begin
                req_addr <= pc;
            end

            if (fill_skid && !i_jump_flag) begin
                skid_inst <= i_imem_rdata;
                skid_addr <= req_addr;
            end

            if (i_jump_flag) begin
                o_valid <= 1'b0;
                o_inst  <= NOP_INST;
            end else if (load_rdata) begin
                o_valid     <= 1'b1;
                o_inst      <= i_imem_rdata;
                o_inst_addr <= req_addr;
            end else if (load_skid) begin
                o_valid     <= 1'b1;
                o_inst      <= skid_inst;
                o_inst_addr <= skid_addr;
            end else if (xfer) begin
                o_valid <= 1'b0;
                o_inst  <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Randomized bench for stage_if: a memory model answers requests, and a monitor checks each
// decode transfer against the expected sequential fetch stream restarted at every redirect.
module tb_stage_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        ready;

    stage_if #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_jump_flag  (jump_flag),
        .i_jump_addr  (jump_addr),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_gnt   (imem_gnt),
        .i_imem_rvalid(imem_rvalid),
        .i_imem_rdata (imem_rdata),
        .o_valid      (valid),
        .o_inst       (inst),
        .o_inst_addr  (inst_addr),
        .i_ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Start addresses of fetch streams, pushed when reset releases or a jump is issued.
    logic [31:0] seg_q[$];

    // Memory-model controls.
    bit gnt_always = 1'b1;
    int lat_max    = 0;

    // Monitor state.
    bit          strict_gap = 1'b0;
    int          cyc        = 0;
    int          xfers      = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: one outstanding request, rvalid 1..lat_max+1 cycles after gnt.
    bit          pending  = 1'b0;
    logic [31:0] pend_addr;
    int          lat      = 0;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend_addr   = 32'h0;
    end

    always begin
        @(posedge clk);
        #1;
        if (pending && lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pending) lat--;
        end
        imem_gnt = pending ? 1'b0 : (gnt_always ? 1'b1 : 1'($urandom_range(0, 1)));
        @(negedge clk);
        if (imem_rvalid) pending = 1'b0;
        if (imem_req && imem_gnt && !rst) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
            lat       = $urandom_range(0, lat_max);
        end
    end

    // Monitor: everything is sampled mid-cycle, describing what the next rising edge does.
    always @(negedge clk) begin
        static bit          have_exp  = 1'b0;
        static logic [31:0] exp_addr  = 32'h0;
        static bit          have_last = 1'b0;
        static int          last_cyc  = 0;
        static int          idle      = 0;
        cyc++;
        if (rst) begin
            chk("reset_valid", 32'(valid), 32'd0);
            chk("reset_req", 32'(imem_req), 32'd0);
            chk("reset_inst", inst, NOP_INST);
            chk("reset_inst_addr", inst_addr, RESET_PC);
            chk("reset_imem_addr", imem_addr, RESET_PC);
            have_exp  = 1'b0;
            have_last = 1'b0;
            idle      = 0;
        end else begin
            if (!have_exp && seg_q.size() > 0) begin
                exp_addr = seg_q.pop_front();
                have_exp = 1'b1;
            end
            if (!valid) chk("nop_when_invalid", inst, NOP_INST);
            if (imem_req) chk("imem_addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (valid && ready) begin
                chk("xfer_addr", inst_addr, exp_addr);
                chk("xfer_inst", inst, mem_word(exp_addr));
                if (strict_gap && have_last) chk("stream_gap", 32'(cyc - last_cyc), 32'd2);
                exp_addr  = exp_addr + 32'd4;
                have_last = 1'b1;
                last_cyc  = cyc;
                xfers++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 300) begin
                    total++;
                    bad++;
                    $display("FAIL liveness actual=%0d idle cycles required<=300", idle);
                    idle = 0;
                end
            end
            if (jump_flag) begin
                if (seg_q.size() > 0) begin
                    exp_addr = seg_q.pop_front();
                    have_exp = 1'b1;
                end
                have_last = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [31:0] target);
        jump_flag = 1'b1;
        jump_addr = target;
        seg_q.push_back({target[31:2], 2'b00});
        tick();
        jump_flag = 1'b0;
        jump_addr = $urandom;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        seg_q.delete();
        repeat (cycles) tick();
        rst = 1'b0;
        seg_q.push_back(RESET_PC);
    endtask

    initial begin
        rst       = 1'b1;
        jump_flag = 1'b0;
        jump_addr = 32'h0;
        ready     = 1'b1;
        #1;
        do_reset(3);

        // Fetch start: IDLE for one cycle, then request at RESET_PC.
        @(negedge clk);
        chk("first_cycle_idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_req_addr", imem_addr, RESET_PC);

        // Full-rate streaming: one instruction every 2 cycles.
        strict_gap = 1'b1;
        repeat (20) tick();
        strict_gap = 1'b0;

        // Backpressure fills output and skid; fetching must pause.
        ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("stall_req_low", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(valid), 32'd1);
        tick();
        ready = 1'b1;
        repeat (10) tick();

        // Directed redirects, including misaligned target and address wrap.
        do_jump(32'h0000_0103);
        repeat (9) tick();
        do_jump(32'h0000_0200);
        repeat (7) tick();
        do_jump(32'hFFFF_FFFC);
        repeat (12) tick();

        // Randomized traffic: variable grant, latency, backpressure and jumps.
        gnt_always = 1'b0;
        lat_max    = 3;
        for (int i = 0; i < 1500; i++) begin
            ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) do_jump(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                else do_jump($urandom);
            end else begin
                tick();
            end
        end

        // Reset while a request is outstanding; the late response must be ignored.
        ready = 1'b1;
        for (int i = 0; i < 50 && !pending; i++) tick();
        chk("reset_test_outstanding", 32'(pending), 32'd1);
        do_reset(2);
        repeat (200) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Drain at full rate.
        gnt_always = 1'b1;
        lat_max    = 0;
        ready      = 1'b1;
        repeat (40) tick();
        chk("progress", 32'(xfers > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
